// File: rtl/sm_datapath.sv
// sm_datapath: 8x16 register file, A/B operand registers, shifter, ALU,
// result register C and a {V,N,Z} status register.
// Every register updates on the rising clk edge from pre-edge values;
// the synchronous active-low reset overrides all write/load enables.
module sm_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [2:0]  writenum,
    input  logic [2:0]  readnum,
    input  logic [1:0]  vsel,
    input  logic [15:0] sximm8,
    input  logic [15:0] sximm5,
    input  logic [15:0] mdata,
    input  logic [7:0]  PC,
    input  logic        loada,
    input  logic        loadb,
    input  logic        loadc,
    input  logic        loads,
    input  logic        asel,
    input  logic        bsel,
    input  logic [1:0]  shift,
    input  logic [1:0]  ALUop,
    output logic [15:0] datapath_out,
    output logic [2:0]  Z_out
);

    logic [15:0] r_regs [0:7];
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_c;
    logic [2:0]  r_status;

    logic [15:0] w_wb;
    logic [15:0] w_rd;
    logic [15:0] w_sout;
    logic [15:0] w_ain;
    logic [15:0] w_bin;
    logic [15:0] w_res;
    logic        w_ovf;

    assign w_rd = r_regs[readnum];

    // Writeback source mux.
    always_comb begin
        w_wb = r_c;
        case (vsel)
            2'b00: w_wb = r_c;
            2'b01: w_wb = {8'b0, PC};
            2'b10: w_wb = sximm8;
            2'b11: w_wb = mdata;
            default: w_wb = r_c;
        endcase
    end

    // Shifter applied to B.
    always_comb begin
        w_sout = r_b;
        case (shift)
            2'b00: w_sout = r_b;
            2'b01: w_sout = {r_b[14:0], 1'b0};
            2'b10: w_sout = {1'b0, r_b[15:1]};
            2'b11: w_sout = {r_b[15], r_b[15:1]};
            default: w_sout = r_b;
        endcase
    end

    assign w_ain = asel ? 16'h0000 : r_a;
    assign w_bin = bsel ? sximm5 : w_sout;

    // ALU with signed overflow detect; logic ops never overflow.
    always_comb begin
        w_res = 16'h0000;
        w_ovf = 1'b0;
        case (ALUop)
            2'b00: begin
                w_res = w_ain + w_bin;
                w_ovf = (w_ain[15] == w_bin[15]) && (w_res[15] != w_ain[15]);
            end
            2'b01: begin
                w_res = w_ain - w_bin;
                w_ovf = (w_ain[15] != w_bin[15]) && (w_res[15] != w_ain[15]);
            end
            2'b10: w_res = w_ain & w_bin;
            2'b11: w_res = ~w_bin;
            default: w_res = 16'h0000;
        endcase
    end

    // Register file, operand, result and status registers; reset wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_c      <= 16'h0000;
            r_status <= 3'b000;
        end else begin
            if (write) begin
                r_regs[writenum] <= w_wb;
            end
            if (loada) begin
                r_a <= w_rd;
            end
            if (loadb) begin
                r_b <= w_rd;
            end
            if (loadc) begin
                r_c <= w_res;
            end
            if (loads) begin
                r_status <= {w_ovf, w_res[15], (w_res == 16'h0000)};
            end
        end
    end

    assign datapath_out = r_c;
    assign Z_out        = r_status;

endmodule

// File: tb/tb_sm_datapath.sv
// Directed vector bench for sm_datapath. Registers are observed by loading
// them into B and passing them through the ALU as 0+B into C.
module tb_sm_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic [1:0]  vsel;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [15:0] mdata;
    logic [7:0]  PC;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] datapath_out;
    logic [2:0]  Z_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [2:0]  wn;
        logic [2:0]  rn;
        logic [1:0]  vs;
        logic [15:0] imm8;
        logic [15:0] imm5;
        logic [15:0] md;
        logic [7:0]  pc;
        logic        la;
        logic        lb;
        logic        lc;
        logic        ls;
        logic        as;
        logic        bs;
        logic [1:0]  sh;
        logic [1:0]  op;
        logic        chk;
        logic [15:0] exp_out;
        logic [2:0]  exp_z;
    } vec_t;

    vec_t vecs[$];

    sm_datapath dut (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum),
        .readnum(readnum), .vsel(vsel), .sximm8(sximm8), .sximm5(sximm5),
        .mdata(mdata), .PC(PC), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .datapath_out(datapath_out),
        .Z_out(Z_out)
    );

    always #5 clk = ~clk;

    function automatic vec_t v_nop();
        vec_t v;
        v = '{rst: 1'b1, wr: 1'b0, wn: 3'd0, rn: 3'd0, vs: 2'd0, imm8: 16'h0,
              imm5: 16'h0, md: 16'h0, pc: 8'h0, la: 1'b0, lb: 1'b0, lc: 1'b0,
              ls: 1'b0, as: 1'b0, bs: 1'b0, sh: 2'd0, op: 2'd0, chk: 1'b0,
              exp_out: 16'h0, exp_z: 3'd0};
        return v;
    endfunction

    function automatic vec_t v_wr(input logic [2:0] wn, input logic [1:0] vs,
                                  input logic [15:0] data, input logic [7:0] pc);
        vec_t v = v_nop();
        v.wr = 1'b1; v.wn = wn; v.vs = vs; v.pc = pc;
        v.imm8 = data; v.md = data;
        return v;
    endfunction

    function automatic vec_t v_ld(input logic [2:0] rn, input logic la, input logic lb);
        vec_t v = v_nop();
        v.rn = rn; v.la = la; v.lb = lb;
        return v;
    endfunction

    function automatic vec_t v_alu(input logic [1:0] sh, input logic [1:0] op,
                                   input logic as, input logic bs,
                                   input logic [15:0] imm5, input logic lc,
                                   input logic ls, input logic [15:0] eo,
                                   input logic [2:0] ez);
        vec_t v = v_nop();
        v.sh = sh; v.op = op; v.as = as; v.bs = bs; v.imm5 = imm5;
        v.lc = lc; v.ls = ls; v.chk = 1'b1; v.exp_out = eo; v.exp_z = ez;
        return v;
    endfunction

    // 0 + B into C without touching status.
    function automatic vec_t v_peek(input logic [15:0] eo, input logic [2:0] ez);
        return v_alu(2'b00, 2'b00, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, eo, ez);
    endfunction

    task automatic apply(input vec_t v, input string name);
        reset = v.rst; write = v.wr; writenum = v.wn; readnum = v.rn;
        vsel = v.vs; sximm8 = v.imm8; sximm5 = v.imm5; mdata = v.md;
        PC = v.pc; loada = v.la; loadb = v.lb; loadc = v.lc; loads = v.ls;
        asel = v.as; bsel = v.bs; shift = v.sh; ALUop = v.op;
        @(posedge clk);
        #1;
        if (v.chk) begin
            checks++;
            if (datapath_out !== v.exp_out) begin
                errors++;
                $display("FAIL %s datapath_out got %h expected %h", name, datapath_out, v.exp_out);
            end
            checks++;
            if (Z_out !== v.exp_z) begin
                errors++;
                $display("FAIL %s Z_out got %b expected %b", name, Z_out, v.exp_z);
            end
        end
    endtask

    initial begin
        vec_t v;

        // Reset, with write/loads asserted to show reset priority.
        v = v_wr(3'd3, 2'b10, 16'h1111, 8'h0);
        v.rst = 1'b0; v.la = 1'b1; v.lb = 1'b1; v.lc = 1'b1; v.ls = 1'b1;
        v.chk = 1'b1; v.exp_out = 16'h0; v.exp_z = 3'b000;
        vecs.push_back(v);
        // MOV R0,#7 and read back.
        v = v_wr(3'd0, 2'b10, 16'h0007, 8'h0); v.chk = 1'b1; vecs.push_back(v);
        vecs.push_back(v_ld(3'd0, 1'b0, 1'b1));
        vecs.push_back(v_peek(16'h0007, 3'b000));
        // R1=2; ADD R2 = R0 + (R1<<1).
        vecs.push_back(v_wr(3'd1, 2'b10, 16'h0002, 8'h0));
        vecs.push_back(v_ld(3'd0, 1'b1, 1'b0));
        vecs.push_back(v_ld(3'd1, 1'b0, 1'b1));
        vecs.push_back(v_alu(2'b01, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h000B, 3'b000));
        vecs.push_back(v_wr(3'd2, 2'b00, 16'h0, 8'h0));
        vecs.push_back(v_ld(3'd2, 1'b0, 1'b1));
        vecs.push_back(v_peek(16'h000B, 3'b000));
        // CMP 7,7: status only, C holds.
        vecs.push_back(v_ld(3'd0, 1'b0, 1'b1));
        vecs.push_back(v_alu(2'b00, 2'b01, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h000B, 3'b001));
        // 7FFF + 1 overflow.
        vecs.push_back(v_wr(3'd3, 2'b11, 16'h7FFF, 8'h0));
        vecs.push_back(v_ld(3'd3, 1'b1, 1'b0));
        vecs.push_back(v_wr(3'd4, 2'b10, 16'h0001, 8'h0));
        vecs.push_back(v_ld(3'd4, 1'b0, 1'b1));
        vecs.push_back(v_alu(2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h8000, 3'b110));
        // AND, then SUB with immediate -1 overflowing.
        vecs.push_back(v_alu(2'b00, 2'b10, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0001, 3'b000));
        vecs.push_back(v_alu(2'b00, 2'b01, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 3'b110));
        // PC writeback zero-extended.
        vecs.push_back(v_wr(3'd5, 2'b01, 16'h0, 8'hA5));
        vecs.push_back(v_ld(3'd5, 1'b0, 1'b1));
        vecs.push_back(v_peek(16'h00A5, 3'b110));
        // MVN of arithmetic-shifted 8004, then logical shift.
        vecs.push_back(v_wr(3'd6, 2'b11, 16'h8004, 8'h0));
        vecs.push_back(v_ld(3'd6, 1'b0, 1'b1));
        vecs.push_back(v_alu(2'b11, 2'b11, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h3FFD, 3'b000));
        vecs.push_back(v_alu(2'b10, 2'b00, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h4002, 3'b000));
        // Write R6 and load A from R6 on the same edge: A gets old 8004.
        v = v_wr(3'd6, 2'b10, 16'h0055, 8'h0);
        v.rn = 3'd6; v.la = 1'b1; v.chk = 1'b1; v.exp_out = 16'h4002; v.exp_z = 3'b000;
        vecs.push_back(v);
        vecs.push_back(v_alu(2'b00, 2'b00, 1'b0, 1'b1, 16'h0, 1'b1, 1'b1, 16'h8004, 3'b010));
        vecs.push_back(v_ld(3'd6, 1'b0, 1'b1));
        vecs.push_back(v_peek(16'h0055, 3'b010));
        // Reset with loadc/loads/write in the same cycle.
        v = v_wr(3'd1, 2'b10, 16'hBEEF, 8'h0);
        v.rst = 1'b0; v.lc = 1'b1; v.ls = 1'b1; v.la = 1'b1;
        v.chk = 1'b1; v.exp_out = 16'h0; v.exp_z = 3'b000;
        vecs.push_back(v);
        for (int r = 0; r < 8; r++) begin
            vecs.push_back(v_ld(r[2:0], 1'b0, 1'b1));
            vecs.push_back(v_peek(16'h0000, 3'b000));
        end
        vecs.push_back(v_alu(2'b00, 2'b00, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0, 16'h0000, 3'b000));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-instruction discards partially loaded A and B.
        apply(v_wr(3'd7, 2'b10, 16'h1234, 8'h0), "mid_wr");
        apply(v_ld(3'd7, 1'b1, 1'b1), "mid_ld");
        apply(v_peek(16'h1234, 3'b000), "mid_peek");
        v = v_ld(3'd7, 1'b1, 1'b1);
        v.rst = 1'b0; v.lc = 1'b1; v.chk = 1'b1; v.exp_out = 16'h0; v.exp_z = 3'b000;
        apply(v, "mid_rst");
        apply(v_alu(2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0000, 3'b001), "mid_a_plus_b");
        apply(v_ld(3'd7, 1'b0, 1'b1), "mid_ld7");
        apply(v_peek(16'h0000, 3'b001), "mid_r7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
